// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the memory address path. The MAR/MDR units and
// mem_responder all take their data and address widths from this package.
//   state_t : mem_responder sequencer states (IDLE, WAIT, DONE)
//   op_t    : latched request kind (OP_RD, OP_WR)
//   ADDR_W  : word-address width (memory depth is 2**ADDR_W)
//   DATA_W  : data word width
//   CNT_W   : width of the wait counter (covers LATENCY-1 up to 14)
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

endpackage

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between the control unit (with MAR/MDR) and the
// memory responder.
//   addr      : word address from MAR
//   din       : write data from MDR
//   read      : level-sensitive read strobe
//   write     : level-sensitive write strobe
//   dout      : registered read data
//   mem_ready : one-cycle completion pulse
//   busy      : request in flight
//   err       : one-cycle pulse when a request is rejected
// master = control side, slave = memory responder side.
// ---------------------------------------------------------------------------
interface mem_responder_if #(
   parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
   parameter int DATA_W = cpu_mem_pkg::DATA_W
);

   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] dout;
   logic              mem_ready;
   logic              busy;
   logic              err;

   modport master (
      output addr, din, read, write,
      input  dout, mem_ready, busy, err
   );

   modport slave (
      input  addr, din, read, write,
      output dout, mem_ready, busy, err
   );

endinterface

// File: rtl/mem_responder_mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// Single-port RAM, DATA_W x 2**ADDR_W. Writes happen on the rising edge when
// we is high; the read data is a plain lookup of addr and is registered by
// the parent. There is deliberately no reset so contents survive a clr.
//   clk   : clock
//   we    : write enable
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : data stored at addr
// ---------------------------------------------------------------------------
module mem_array #(
   parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
   parameter int DATA_W = cpu_mem_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Synchronous write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Memory-side responder. Accepts a read or write request in IDLE, waits
// LATENCY cycles, performs the access on the RAM, then pulses mem_ready for
// one cycle. Requests with both strobes high are rejected with an err pulse.
//   clk  : system clock
//   clr  : asynchronous active-low reset (RAM contents are kept)
//   bus  : mem_responder_if slave (addr, din, read, write in;
//          dout, mem_ready, busy, err out)
// Parameter LATENCY (1..15): edges from acceptance to the memory access.
// ---------------------------------------------------------------------------
module mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int LATENCY = 2
) (
   input  logic            clk,
   input  logic            clr,
   mem_responder_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   op_t               req_op;
   logic [DATA_W-1:0] dout_q;
   logic              ready_q;
   logic              busy_q;
   logic              err_q;
   logic [DATA_W-1:0] rd_data;
   logic              access;
   logic              mem_we;

   // The access edge is the last WAIT cycle. Because state is forced to
   // IDLE by clr, an aborted request can never reach the write enable.
   assign access = (state == WAIT) && (cnt == '0);
   assign mem_we = access && (req_op == OP_WR);

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (req_addr),
      .wdata (req_data),
      .rdata (rd_data)
   );

   // Sequencer, wait counter, request latches and all registered outputs.
   // mem_ready and err default low so they can only ever pulse one cycle
   // per triggering event; busy follows the next state so it is high
   // exactly while the sequencer is outside IDLE.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= IDLE;
         cnt      <= '0;
         req_addr <= '0;
         req_data <= '0;
         req_op   <= OP_RD;
         dout_q   <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.read ^ bus.write) begin
                  req_addr <= bus.addr;
                  req_data <= bus.din;
                  req_op   <= bus.write ? OP_WR : OP_RD;
                  cnt      <= CNT_LOAD;
                  state    <= WAIT;
                  busy_q   <= 1'b1;
               end else if (bus.read && bus.write) begin
                  err_q <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  if (req_op == OP_RD) begin
                     dout_q <= rd_data;
                  end
                  ready_q <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dout      = dout_q;
   assign bus.mem_ready = ready_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Two responders share clk/clr: dut_a with LATENCY 2 and dut_b with
// LATENCY 1. A transaction-level model (memory array plus last read value
// per DUT) supplies expected data; latency expectations come straight from
// the LATENCY parameters.
// ---------------------------------------------------------------------------
module tb_mem_responder;
   import cpu_mem_pkg::*;

   localparam int LAT_A = 2;
   localparam int LAT_B = 1;

   logic clk = 1'b0;
   logic clr;

   always #5 clk = ~clk;

   mem_responder_if bus_a ();
   mem_responder_if bus_b ();

   mem_responder #(.LATENCY(LAT_A)) dut_a (.clk(clk), .clr(clr), .bus(bus_a));
   mem_responder #(.LATENCY(LAT_B)) dut_b (.clk(clk), .clr(clr), .bus(bus_b));

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] model_mem   [2][512];
   bit          model_valid [2][512];
   logic [31:0] model_dout  [2];

   typedef struct {
      int          sel;
      op_t         op;
      logic [8:0]  addr;
      logic [31:0] data;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vecs [$];

   // Compare one value and log it when it disagrees.
   task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int sel, logic rd, logic wr, logic [8:0] a, logic [31:0] d);
      if (sel == 0) begin
         bus_a.read = rd; bus_a.write = wr; bus_a.addr = a; bus_a.din = d;
      end else begin
         bus_b.read = rd; bus_b.write = wr; bus_b.addr = a; bus_b.din = d;
      end
   endtask

   function automatic logic [31:0] get_dout(int sel);
      return (sel == 0) ? bus_a.dout : bus_b.dout;
   endfunction

   function automatic logic get_ready(int sel);
      return (sel == 0) ? bus_a.mem_ready : bus_b.mem_ready;
   endfunction

   function automatic logic get_busy(int sel);
      return (sel == 0) ? bus_a.busy : bus_b.busy;
   endfunction

   function automatic logic get_err(int sel);
      return (sel == 0) ? bus_a.err : bus_b.err;
   endfunction

   function automatic int lat(int sel);
      return (sel == 0) ? LAT_A : LAT_B;
   endfunction

   // One complete request: accept, scramble the inputs while busy, wait for
   // mem_ready with a bound, then check latency, data and return to idle.
   task automatic apply_stimulus(int sel, op_t op, logic [8:0] a, logic [31:0] d,
                                 logic [31:0] exp_dout, string name);
      int got;
      got = -1;
      drive(sel, op == OP_RD, op == OP_WR, a, d);
      tick();
      check_output({name, " busy_on"}, 32'(get_busy(sel)), 32'd1);
      drive(sel, 1'b0, 1'b0, ~a, ~d);
      for (int n = 1; n <= lat(sel) + 4; n++) begin
         tick();
         if (get_ready(sel)) begin
            got = n;
            break;
         end
      end
      check_output({name, " ready_lat"}, 32'(got), 32'(lat(sel)));
      check_output({name, " busy_at_ready"}, 32'(get_busy(sel)), 32'd1);
      check_output({name, " dout"}, get_dout(sel), exp_dout);
      tick();
      check_output({name, " ready_off"}, 32'(get_ready(sel)), 32'd0);
      check_output({name, " busy_off"}, 32'(get_busy(sel)), 32'd0);
      if (op == OP_WR) begin
         model_mem[sel][a]   = d;
         model_valid[sel][a] = 1'b1;
      end else begin
         model_dout[sel] = model_mem[sel][a];
      end
   endtask

   // Safety net so the run always ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          pulses [$];
      logic [31:0] pdata  [$];
      int          cnt_pulse;
      int          sel;
      op_t         op;
      logic [8:0]  a;
      logic [31:0] d;
      logic [31:0] exp;

      model_dout[0] = '0;
      model_dout[1] = '0;
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);

      // Power-up reset: outputs must be clear without any clock edge.
      clr = 1'b1;
      #3 clr = 1'b0;
      #1;
      check_output("por dout",  bus_a.dout,              32'h0);
      check_output("por ready", 32'(bus_a.mem_ready),    32'd0);
      check_output("por busy",  32'(bus_a.busy),         32'd0);
      check_output("por err",   32'(bus_a.err),          32'd0);
      @(posedge clk);
      #3 clr = 1'b1;
      tick();

      // Directed vector table.
      vecs.push_back('{0, OP_WR, 9'h1FF, 32'hDEADBEEF, 32'h00000000});
      vecs.push_back('{0, OP_RD, 9'h1FF, 32'h00000000, 32'hDEADBEEF});
      vecs.push_back('{0, OP_WR, 9'h000, 32'h11111111, 32'hDEADBEEF});
      vecs.push_back('{0, OP_WR, 9'h010, 32'hCAFEF00D, 32'hDEADBEEF});
      vecs.push_back('{0, OP_RD, 9'h010, 32'h00000000, 32'hCAFEF00D});
      vecs.push_back('{0, OP_RD, 9'h000, 32'h00000000, 32'h11111111});
      vecs.push_back('{1, OP_WR, 9'h000, 32'hA5A5A5A5, 32'h00000000});
      vecs.push_back('{1, OP_WR, 9'h001, 32'h5A5A5A5A, 32'h00000000});
      vecs.push_back('{1, OP_RD, 9'h001, 32'h00000000, 32'h5A5A5A5A});
      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i].sel, vecs[i].op, vecs[i].addr, vecs[i].data,
                        vecs[i].exp_dout, $sformatf("vec%0d", i));
      end

      // Both strobes high for two cycles: err each cycle, nothing accepted.
      drive(0, 1'b1, 1'b1, 9'h1FF, 32'h0);
      tick();
      check_output("both1 err",  32'(get_err(0)),  32'd1);
      check_output("both1 busy", 32'(get_busy(0)), 32'd0);
      tick();
      check_output("both2 err",  32'(get_err(0)),  32'd1);
      check_output("both2 busy", 32'(get_busy(0)), 32'd0);
      drive(0, 1'b0, 1'b0, '0, '0);
      tick();
      check_output("both_end err", 32'(get_err(0)), 32'd0);
      check_output("both dout", get_dout(0), 32'h11111111);
      apply_stimulus(0, OP_RD, 9'h1FF, '0, 32'hDEADBEEF, "both_readback");

      // Reset during WAIT of a write: no completion, RAM keeps old value.
      drive(0, 1'b0, 1'b1, 9'h010, 32'h12345678);
      tick();
      drive(0, 1'b0, 1'b0, '0, '0);
      #2 clr = 1'b0;
      #1;
      check_output("rst dout",   bus_a.dout,           32'h0);
      check_output("rst ready",  32'(bus_a.mem_ready), 32'd0);
      check_output("rst busy",   32'(bus_a.busy),      32'd0);
      check_output("rst err",    32'(bus_a.err),       32'd0);
      check_output("rst b dout", bus_b.dout,           32'h0);
      #2 clr = 1'b1;
      model_dout[0] = '0;
      model_dout[1] = '0;
      cnt_pulse = 0;
      for (int n = 0; n < 5; n++) begin
         tick();
         if (get_ready(0)) cnt_pulse++;
      end
      check_output("rst no_ready", 32'(cnt_pulse), 32'd0);
      apply_stimulus(0, OP_RD, 9'h010, '0, 32'hCAFEF00D, "rst_readback");

      // Back-to-back reads on the LATENCY 1 responder with the strobe held.
      drive(1, 1'b1, 1'b0, 9'h000, '0);
      tick();
      drive(1, 1'b1, 1'b0, 9'h001, '0);
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (get_ready(1)) begin
            pulses.push_back(c);
            pdata.push_back(get_dout(1));
         end
      end
      drive(1, 1'b0, 1'b0, '0, '0);
      tick();
      check_output("b2b count", 32'(pulses.size()), 32'd3);
      check_output("b2b first", 32'((pulses.size() > 0) ? pulses[0] : -1), 32'd1);
      check_output("b2b gap1",
                   32'((pulses.size() > 1) ? pulses[1] - pulses[0] : -1), 32'd3);
      check_output("b2b gap2",
                   32'((pulses.size() > 2) ? pulses[2] - pulses[1] : -1), 32'd3);
      check_output("b2b data0", (pdata.size() > 0) ? pdata[0] : 32'hX, model_mem[1][0]);
      check_output("b2b data1", (pdata.size() > 1) ? pdata[1] : 32'hX, model_mem[1][1]);
      check_output("b2b data2", (pdata.size() > 2) ? pdata[2] : 32'hX, model_mem[1][1]);
      model_dout[1] = model_mem[1][1];

      // Randomized traffic against the model.
      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 1));
         a   = 9'($urandom_range(0, 7) * 64 + $urandom_range(0, 1));
         d   = $urandom;
         op  = ($urandom_range(0, 1) == 1) ? OP_RD : OP_WR;
         if (op == OP_RD && !model_valid[sel][a]) op = OP_WR;
         exp = (op == OP_RD) ? model_mem[sel][a] : model_dout[sel];
         apply_stimulus(sel, op, a, d, exp, $sformatf("rand%0d", i));
         for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
